status_reg: RTL and testbench

STATUS_REG -- requirements
Module: status_reg

---
 rtl/status_reg_pkg.sv | 12 +
 rtl/status_reg_if.sv | 13 +
 rtl/status_reg_flag_bit.sv | 11 +
 rtl/status_reg.sv | 24 ++
 tb/tb_status_reg.sv | 87 ++++++++
 5 files changed

// File: rtl/status_reg_pkg.sv
// status_reg_pkg: 6502 status flag bit positions and reset value.
package status_reg_pkg;
  localparam int C = 0;
  localparam int Z = 1;
  localparam int I = 2;
  localparam int D = 3;
  localparam int B = 4;
  localparam int U = 5;
  localparam int V = 6;
  localparam int N = 7;
  localparam logic [7:0] STATUS_RST = 8'h24;
endpackage

// File: rtl/status_reg_if.sv
// status_reg_if: flag inputs and status byte of the processor status register.
interface status_reg_if;
  logic carry;
  logic zero;
  logic overflow;
  logic neg;
  logic irqdis;
  logic decmode;
  logic brk;
  logic [7:0] status;
  modport master (output carry, zero, overflow, neg, irqdis, decmode, brk, input status);
  modport slave (input carry, zero, overflow, neg, irqdis, decmode, brk, output status);
endinterface

// File: rtl/status_reg_flag_bit.sv
// flag_bit: single status flag flip-flop with synchronous reset to RST_VAL.
module flag_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) q <= reset ? RST_VAL : d;
endmodule

// File: rtl/status_reg.sv
// status_reg: registered 6502 processor status byte, one flop per flag, bit 5 tied high.
module status_reg
  import status_reg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       carry,
  input  logic       zero,
  input  logic       overflow,
  input  logic       neg,
  input  logic       irqdis,
  input  logic       decmode,
  input  logic       brk,
  output logic [7:0] status
);
  flag_bit #(.RST_VAL(STATUS_RST[C])) u_c (.clk(clk), .reset(reset), .d(carry),    .q(status[C]));
  flag_bit #(.RST_VAL(STATUS_RST[Z])) u_z (.clk(clk), .reset(reset), .d(zero),     .q(status[Z]));
  flag_bit #(.RST_VAL(STATUS_RST[I])) u_i (.clk(clk), .reset(reset), .d(irqdis),   .q(status[I]));
  flag_bit #(.RST_VAL(STATUS_RST[D])) u_d (.clk(clk), .reset(reset), .d(decmode),  .q(status[D]));
  flag_bit #(.RST_VAL(STATUS_RST[B])) u_b (.clk(clk), .reset(reset), .d(brk),      .q(status[B]));
  flag_bit #(.RST_VAL(STATUS_RST[V])) u_v (.clk(clk), .reset(reset), .d(overflow), .q(status[V]));
  flag_bit #(.RST_VAL(STATUS_RST[N])) u_n (.clk(clk), .reset(reset), .d(neg),      .q(status[N]));
  assign status[U] = 1'b1;
endmodule

// File: tb/tb_status_reg.sv
// tb_status_reg: scoreboard bench; stimulus queues expected status, monitor checks at each falling edge.
module tb_status_reg;
  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int compared = 0;
  int mismatched = 0;
  exp_t sb[$];

  status_reg_if sif();

  status_reg dut (
    .clk(clk), .reset(reset),
    .carry(sif.carry), .zero(sif.zero), .overflow(sif.overflow), .neg(sif.neg),
    .irqdis(sif.irqdis), .decmode(sif.decmode), .brk(sif.brk),
    .status(sif.status)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [7:0] f, input logic [7:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    #1;
    reset = r;
    sif.carry = f[0];
    sif.zero = f[1];
    sif.irqdis = f[2];
    sif.decmode = f[3];
    sif.brk = f[4];
    sif.overflow = f[6];
    sif.neg = f[7];
    e.exp = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compared++;
        if (sif.status !== e.exp) begin
          mismatched++;
          $display("FAIL %s: status=%h expected=%h", e.name, sif.status, e.exp);
        end
      end
    end
  end

  initial begin
    logic [7:0] walk [7];
    walk = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h40, 8'h80};
    sif.carry = 0; sif.zero = 0; sif.overflow = 0; sif.neg = 0;
    sif.irqdis = 0; sif.decmode = 0; sif.brk = 0;
    step(1'b1, 8'h00, 8'h24, "reset_zero_inputs");
    step(1'b0, 8'h89, 8'hA9, "c_n_d_load");
    step(1'b0, 8'hDF, 8'hFF, "all_ones");
    step(1'b0, 8'h00, 8'h20, "all_zeros");
    step(1'b1, 8'hDF, 8'h24, "reset_priority");
    step(1'b1, 8'hFF, 8'h24, "reset_held");
    step(1'b0, 8'h00, 8'h20, "first_after_reset");
    @(posedge clk);
    #2 sif.zero = 1'b1;
    step(1'b0, 8'h02, 8'h22, "zero_follows");
    step(1'b0, 8'h40, 8'h60, "pre_mid_reset");
    @(posedge clk);
    #2 reset = 1'b1;
    step(1'b0, 8'h00, 8'h20, "after_mid_reset");
    for (int k = 0; k < 7; k++)
      step(1'b0, walk[k], walk[k] | 8'h20, $sformatf("walk_%0d", k));
    step(1'b1, 8'h00, 8'h24, "final_reset");
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      mismatched++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
